priority_encoder: RTL and testbench

PRIORITY_ENCODER -- requirements
Module: priority_encoder

---
 rtl/priority_encoder_pkg.sv | 27 ++
 rtl/penc_core.sv | 26 ++
 rtl/priority_encoder.sv | 90 +++++++++
 tb/tb_priority_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared constants and the reference highest-set-bit search for the priority encoder.
package priority_encoder_pkg;

   localparam int unsigned DefaultWidth = 4;
   localparam int unsigned MaxWidth     = 64;
   localparam int unsigned MaxIdxW      = 6;

   typedef struct packed {
      logic [MaxIdxW-1:0] idx;
      logic               valid;
   } penc_res_t;

   // Later (higher) set bits overwrite earlier ones, so the top set bit wins.
   function automatic penc_res_t highest_set(input logic [MaxWidth-1:0] vec);
      penc_res_t res;
      res.idx   = '0;
      res.valid = 1'b0;
      for (int i = 0; i < int'(MaxWidth); i++) begin
         if (vec[i]) begin
            res.idx   = MaxIdxW'(i);
            res.valid = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/penc_core.sv
// Purely combinational priority encoder: highest set index, any/multi flags and one-hot grant.
module penc_core
   import priority_encoder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned YW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] S,
   output logic [YW-1:0]    idx,
   output logic             any,
   output logic             multi,
   output logic [WIDTH-1:0] onehot
);

   penc_res_t res;

   always_comb begin
      res    = highest_set(MaxWidth'(S));
      idx    = YW'(res.idx);
      any    = res.valid;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi  = (S & (S - WIDTH'(1))) != '0;
      onehot = res.valid ? (WIDTH'(1) << idx) : '0;
   end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: enable-gated output flops around penc_core.
// Define PRIORITY_ENCODER_ONEHOT_EN to add the registered one-hot grant output G.
module priority_encoder
   import priority_encoder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned YW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] S,
   output logic [YW-1:0]    Y,
   output logic             V,
   output logic             M
`ifdef PRIORITY_ENCODER_ONEHOT_EN
   ,
   output logic [WIDTH-1:0] G
`endif
);

   logic [YW-1:0]    idx_w;
   logic             any_w;
   logic             multi_w;
   logic [WIDTH-1:0] onehot_w;

   logic [YW-1:0] y_d, y_q;
   logic          v_d, v_q;
   logic          m_d, m_q;

   penc_core #(
      .WIDTH (WIDTH),
      .YW    (YW)
   ) u_core (
      .S      (S),
      .idx    (idx_w),
      .any    (any_w),
      .multi  (multi_w),
      .onehot (onehot_w)
   );

   always_comb begin
      y_d = y_q;
      v_d = v_q;
      m_d = m_q;
      if (en) begin
         y_d = any_w ? idx_w : '0;
         v_d = |onehot_w;
         m_d = multi_w;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
         v_q <= 1'b0;
         m_q <= 1'b0;
      end else begin
         y_q <= y_d;
         v_q <= v_d;
         m_q <= m_d;
      end
   end

   assign Y = y_q;
   assign V = v_q;
   assign M = m_q;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
   logic [WIDTH-1:0] g_d, g_q;

   always_comb begin
      g_d = g_q;
      if (en) begin
         g_d = onehot_w;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q <= '0;
      end else begin
         g_q <= g_d;
      end
   end

   assign G = g_q;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder at WIDTH=4 and WIDTH=6 (G checked when enabled).
module tb_priority_encoder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] s4;
   logic [5:0] s6;
   logic [1:0] y4;
   logic       v4, m4;
   logic [2:0] y6;
   logic       v6, m6;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
   logic [3:0] g4;
   logic [5:0] g6;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // Model state: what the outputs must show after the most recent enabled edge.
   int unsigned mdl_y4 = 0, mdl_y6 = 0;
   bit          mdl_v4 = 0, mdl_v6 = 0;
   bit          mdl_m4 = 0, mdl_m6 = 0;

   priority_encoder #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .S     (s4),
      .Y     (y4),
      .V     (v4),
      .M     (m4)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      ,
      .G     (g4)
`endif
   );

   priority_encoder #(.WIDTH(6)) u_dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .S     (s6),
      .Y     (y6),
      .V     (v6),
      .M     (m6)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      ,
      .G     (g6)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // floor(log2(s)) by repeated halving; 0 for s=0.
   function automatic int unsigned top_index(input logic [63:0] s);
      int unsigned n = 0;
      while (s > 64'd1) begin
         s = s >> 1;
         n++;
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_y4 <= 0; mdl_v4 <= 0; mdl_m4 <= 0;
         mdl_y6 <= 0; mdl_v6 <= 0; mdl_m6 <= 0;
      end else if (en) begin
         mdl_y4 <= top_index(64'(s4));
         mdl_v4 <= (s4 != 0);
         mdl_m4 <= ($countones(s4) > 1);
         mdl_y6 <= top_index(64'(s6));
         mdl_v6 <= (s6 != 0);
         mdl_m6 <= ($countones(s6) > 1);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_w4_y", 64'(y4), 64'(mdl_y4));
         chk("model_w4_v", 64'(v4), 64'(mdl_v4));
         chk("model_w4_m", 64'(m4), 64'(mdl_m4));
         chk("model_w6_y", 64'(y6), 64'(mdl_y6));
         chk("model_w6_v", 64'(v6), 64'(mdl_v6));
         chk("model_w6_m", 64'(m6), 64'(mdl_m6));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
         chk("model_w4_g", 64'(g4), mdl_v4 ? (64'd1 << mdl_y4) : 64'd0);
         chk("model_w6_g", 64'(g6), mdl_v6 ? (64'd1 << mdl_y6) : 64'd0);
`endif
      end
   end

   // Drive one cycle of inputs, then check the WIDTH=4 outputs after the capturing edge.
   task automatic step(input logic [3:0] a, input logic [5:0] b, input logic e,
                       input int ey, input int ev, input int em);
      s4 = a;
      s6 = b;
      en = e;
      @(negedge clk);
      chk("w4_y", 64'(y4), 64'(ey));
      chk("w4_v", 64'(v4), 64'(ev));
      chk("w4_m", 64'(m4), 64'(em));
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_w4_y"}, 64'(y4), 64'd0);
      chk({tag, "_w4_v"}, 64'(v4), 64'd0);
      chk({tag, "_w4_m"}, 64'(m4), 64'd0);
      chk({tag, "_w6_y"}, 64'(y6), 64'd0);
      chk({tag, "_w6_v"}, 64'(v6), 64'd0);
      chk({tag, "_w6_m"}, 64'(m6), 64'd0);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      chk({tag, "_w4_g"}, 64'(g4), 64'd0);
      chk({tag, "_w6_g"}, 64'(g6), 64'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      s4    = 4'b1111;
      s6    = 6'b111111;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk_en = 1'b1;
      #1 rst_n = 1'b1;

      step(4'b1111, 6'b111111, 1'b1, 3, 1, 1);
      chk("w6_all_y", 64'(y6), 64'd5);
      chk("w6_all_m", 64'(m6), 64'd1);

      step(4'b0001, 6'b000001, 1'b1, 0, 1, 0);
      step(4'b0010, 6'b000010, 1'b1, 1, 1, 0);
      step(4'b0100, 6'b000100, 1'b1, 2, 1, 0);
      step(4'b1000, 6'b100100, 1'b1, 3, 1, 0);
      chk("w6_100100_y", 64'(y6), 64'd5);
      chk("w6_100100_v", 64'(v6), 64'd1);
      chk("w6_100100_m", 64'(m6), 64'd1);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      chk("w6_100100_g", 64'(g6), 64'b100000);
      chk("w4_1000_g", 64'(g4), 64'b1000);
`endif

      step(4'b0000, 6'b000000, 1'b1, 0, 0, 0);
      step(4'b0101, 6'b011000, 1'b1, 2, 1, 1);
      chk("w6_011000_y", 64'(y6), 64'd4);
      step(4'b0011, 6'b000011, 1'b1, 1, 1, 1);
      step(4'b1000, 6'b010000, 1'b1, 3, 1, 0);
      step(4'b0001, 6'b000001, 1'b0, 3, 1, 0);
      chk("w6_hold_y", 64'(y6), 64'd4);
      chk("w6_hold_m", 64'(m6), 64'd0);

      // Capture on the edge, then reset mid-cycle: outputs must clear without a clock.
      s4 = 4'b0010;
      s6 = 6'b100100;
      en = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      en    = 1'b0;
      s4    = 4'b1000;
      s6    = 6'b100000;
      @(negedge clk);
      chk_all_zero("post_rst_hold");
      #1;
      step(4'b1000, 6'b100000, 1'b1, 3, 1, 0);
      chk("w6_final_y", 64'(y6), 64'd5);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
